// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue: memory window defaults,
// the nop word, the queue entry layout and the fetch-address check.
package if_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [31:0] IF_IM_BASE  = 32'h0000_3000;
    localparam int unsigned IF_IM_WORDS = 4096;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef struct packed {
        logic            busy;
        logic            filled;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } if_entry_t;

    // Misaligned, or outside [base, base + 4*words).
    function automatic logic addr_fault(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input int unsigned words);
        logic [32:0] lim;
        lim = {1'b0, base} + 33'(words) * 33'd4;
        return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= lim);
    endfunction

endpackage

// File: rtl/if_slot_ring.sv
// Entry storage for the fetch queue with head/alloc/fill pointers.
// Each pointer carries an extra wrap bit so full and empty can be told apart.
module if_slot_ring
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned IW   = $clog2(DEPTH),
    localparam int unsigned PW   = IW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [31:0]     alloc_pc,
    input  logic            alloc_fault,
    input  logic            fill_en,
    input  logic [31:0]     fill_data,
    input  logic            pop_en,
    output logic [PW-1:0]   count,
    output logic [PW-1:0]   unanswered,
    output logic            fill_avail,
    output if_entry_t       head_entry
);

    if_entry_t     slot_q [DEPTH];
    if_entry_t     slot_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] fill_eff;

    always_comb begin
        // Faulted entries are allocated already filled; the fill pointer
        // steps over them so responses land on the oldest unfilled entry.
        fill_eff = fill_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fill_eff != alloc_q && slot_q[fill_eff[IW-1:0]].filled)
                fill_eff = fill_eff + PW'(1);
        end

        unanswered = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            unanswered = unanswered + PW'(slot_q[i].busy & ~slot_q[i].filled);

        count      = alloc_q - head_q;
        fill_avail = (fill_eff != alloc_q);
        head_entry = slot_q[head_q[IW-1:0]];

        slot_d  = slot_q;
        head_d  = head_q;
        alloc_d = alloc_q;
        fill_d  = fill_eff;

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_d[i].busy   = 1'b0;
                slot_d[i].filled = 1'b0;
            end
            head_d  = '0;
            alloc_d = '0;
            fill_d  = '0;
        end else begin
            if (alloc_en) begin
                slot_d[alloc_q[IW-1:0]] = '{busy: 1'b1, filled: alloc_fault,
                                            pc: alloc_pc, instr: NOP_INSTR,
                                            fault: alloc_fault};
                alloc_d = alloc_q + PW'(1);
            end
            if (fill_en) begin
                slot_d[fill_eff[IW-1:0]].filled = 1'b1;
                slot_d[fill_eff[IW-1:0]].instr  = fill_data;
                fill_d = fill_eff + PW'(1);
            end
            if (pop_en) begin
                slot_d[head_q[IW-1:0]].busy   = 1'b0;
                slot_d[head_q[IW-1:0]].filled = 1'b0;
                head_d = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                slot_q[i] <= '0;
            head_q  <= '0;
            alloc_q <= '0;
            fill_q  <= '0;
        end else begin
            slot_q  <= slot_d;
            head_q  <= head_d;
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues in-order memory requests for pc_in,
// buffers returned words and hands them to decode. Redirect flushes the queue
// and drops responses still in flight. Define IF_FETCH_CHECK_EN to enable the
// fetch-address alignment/range check (faulting fetches bypass the memory).
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] IM_BASE  = IF_IM_BASE,
    parameter int unsigned IM_WORDS = IF_IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        fetch_fire,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int unsigned PW  = $clog2(DEPTH) + 1;
    localparam int unsigned DW  = 8;
    localparam int unsigned DW1 = DW + 1;

`ifdef IF_FETCH_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic [PW-1:0] count;
    logic [PW-1:0] unanswered;
    logic          fill_avail;
    if_entry_t     head;
    logic          pc_fault;
    logic          issue_ok;
    logic          rsp_fill;
    logic          pop;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;
    logic [DW1-1:0] drop_sum;

    assign pc_fault       = CHECK_EN && addr_fault(pc_in, IM_BASE, IM_WORDS);
    assign issue_ok       = !reset && !redirect && (count < PW'(DEPTH));
    assign imem_req_valid = issue_ok && !pc_fault;
    assign fetch_fire     = issue_ok && (pc_fault || imem_req_ready);
    assign imem_req_addr  = pc_in;

    assign rsp_fill = imem_rsp_valid && !redirect && (drop_cnt_q == '0) && fill_avail;
    assign id_valid = head.busy && head.filled;
    assign pop      = id_valid && id_ready && !redirect;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;
    assign id_fault = CHECK_EN ? head.fault : 1'b0;

    if_slot_ring #(.DEPTH(DEPTH)) u_ring (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect),
        .alloc_en    (fetch_fire),
        .alloc_pc    (pc_in),
        .alloc_fault (pc_fault),
        .fill_en     (rsp_fill),
        .fill_data   (imem_rsp_data),
        .pop_en      (pop),
        .count       (count),
        .unanswered  (unanswered),
        .fill_avail  (fill_avail),
        .head_entry  (head)
    );

    // On redirect every unanswered request joins the drop count; a response
    // arriving that same cycle retires the oldest outstanding one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + DW1'(unanswered);
        if (redirect) begin
            if (imem_rsp_valid && drop_sum != '0)
                drop_sum = drop_sum - DW1'(1);
            drop_cnt_d = drop_sum[DW-1:0];
        end else if (imem_rsp_valid && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    rsp_has_target: assert property (@(posedge clk) disable iff (reset)
        !imem_rsp_valid || drop_cnt_q != '0 || fill_avail);

endmodule
